// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: registered N:1 selector for a pipeline-register boundary.
// Picks one of NUM_IN packed inputs by Sel. The pick is captured into the
// stage register under the usual flush/stall rules. Out-of-range selects are
// flagged and counted. Every output comes straight from a flop.
module mux_nx1_pipe #(
    parameter int              WIDTH       = 5,
    parameter int              NUM_IN      = 3,
    parameter int              SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int              CNT_W       = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_IN*WIDTH-1:0] InBus,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    InValid,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    output logic                    SelErr,
    output logic [CNT_W-1:0]        ErrCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] nxt;
    logic             nerr;
    logic             capture;

    // A stage capture happens only when the register is neither flushed nor held
    assign capture = !Flush && !Stall;

    // Out-of-range detection; when every Sel code maps to an input, no code is illegal
    generate
        if (NUM_IN == (2 ** SEL_W)) begin : g_full_range
            assign nerr = 1'b0;
        end else begin : g_partial_range
            localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);
            assign nerr = ({1'b0, Sel} >= NUM_IN_EXT);
        end
    endgenerate

    // Combinational pick; an unmatched (out-of-range) Sel leaves the default value
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        nxt = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (Sel == SEL_W'(k)) begin
                nxt = InBus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Stage register for data, valid and error flag: flush beats stall beats capture
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) begin
            Out      <= '0;
            OutValid <= 1'b0;
            SelErr   <= 1'b0;
        end else if (Flush) begin
            Out      <= '0;
            OutValid <= 1'b0;
            SelErr   <= 1'b0;
        end else if (!Stall) begin
            Out      <= nxt;
            OutValid <= InValid;
            SelErr   <= nerr & InValid;
        end
    end

    // Saturating count of valid out-of-range captures; only reset clears it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ErrCount <= '0;
        end else if (capture && InValid && nerr && (ErrCount != CNT_MAX)) begin
            ErrCount <= ErrCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb_mux_nx1_pipe: self-checking bench for mux_nx1_pipe.
// Three instances share the clock and the control inputs:
//   a : default build (5-bit, 3 inputs, 2-bit select, 8-bit counter)
//   s : same as a but with a 3-bit counter, to show saturation
//   w : 32-bit, 5 inputs, 3-bit select
// A behavioural model built from array indexing predicts every output after each edge.
module tb_mux_nx1_pipe;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic        inv;
    logic        stall;
    logic        flush;

    logic [4:0]   in_a [3];
    logic [31:0]  in_w [5];
    logic [14:0]  bus_a;
    logic [159:0] bus_w;

    logic [4:0]  out_a;  logic val_a; logic err_a; logic [7:0] cnt_a;
    logic [4:0]  out_s;  logic val_s; logic err_s; logic [2:0] cnt_s;
    logic [31:0] out_w;  logic val_w; logic err_w; logic [7:0] cnt_w;

    int total = 0;
    int bad   = 0;

    // model state
    logic [4:0]  m_out_a;
    bit          m_val_a, m_err_a;
    logic [31:0] m_out_w;
    bit          m_val_w, m_err_w;
    int          m_cnt_a, m_cnt_s, m_cnt_w;

    for (genvar k = 0; k < 3; k++) begin : g_pack_a
        assign bus_a[k*5 +: 5] = in_a[k];
    end
    for (genvar k = 0; k < 5; k++) begin : g_pack_w
        assign bus_w[k*32 +: 32] = in_w[k];
    end

    mux_nx1_pipe u_dut_a (
        .Clk(clk), .Rst_n(rst_n), .InBus(bus_a), .Sel(sel[1:0]), .InValid(inv),
        .Stall(stall), .Flush(flush), .Out(out_a), .OutValid(val_a),
        .SelErr(err_a), .ErrCount(cnt_a)
    );

    mux_nx1_pipe #(.CNT_W(3)) u_dut_s (
        .Clk(clk), .Rst_n(rst_n), .InBus(bus_a), .Sel(sel[1:0]), .InValid(inv),
        .Stall(stall), .Flush(flush), .Out(out_s), .OutValid(val_s),
        .SelErr(err_s), .ErrCount(cnt_s)
    );

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) u_dut_w (
        .Clk(clk), .Rst_n(rst_n), .InBus(bus_w), .Sel(sel), .InValid(inv),
        .Stall(stall), .Flush(flush), .Out(out_w), .OutValid(val_w),
        .SelErr(err_w), .ErrCount(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out_a = '0; m_val_a = 0; m_err_a = 0;
        m_out_w = '0; m_val_w = 0; m_err_w = 0;
        m_cnt_a = 0;  m_cnt_s = 0; m_cnt_w = 0;
    endtask

    // Apply the stage rules to the inputs present at this rising edge
    task automatic model_edge();
        int  sa, sw;
        bit  oor_a, oor_w;
        sa    = int'(sel[1:0]);
        sw    = int'(sel);
        oor_a = (sa >= 3);
        oor_w = (sw >= 5);
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_out_a = '0; m_val_a = 0; m_err_a = 0;
            m_out_w = '0; m_val_w = 0; m_err_w = 0;
        end else if (!stall) begin
            m_out_a = oor_a ? 5'd0 : in_a[sa];
            m_val_a = inv;
            m_err_a = oor_a && inv;
            if (oor_a && inv) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_s < 7)   m_cnt_s++;
            end
            m_out_w = oor_w ? 32'd0 : in_w[sw];
            m_val_w = inv;
            m_err_w = oor_w && inv;
            if (oor_w && inv && m_cnt_w < 255) m_cnt_w++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a_out"}, out_a, m_out_a);
        check({tag, ".a_val"}, val_a, m_val_a);
        check({tag, ".a_err"}, err_a, m_err_a);
        check({tag, ".a_cnt"}, cnt_a, m_cnt_a);
        check({tag, ".s_out"}, out_s, m_out_a);
        check({tag, ".s_val"}, val_s, m_val_a);
        check({tag, ".s_err"}, err_s, m_err_a);
        check({tag, ".s_cnt"}, cnt_s, m_cnt_s);
        check({tag, ".w_out"}, out_w, m_out_w);
        check({tag, ".w_val"}, val_w, m_val_w);
        check({tag, ".w_err"}, err_w, m_err_w);
        check({tag, ".w_cnt"}, cnt_w, m_cnt_w);
    endtask

    // One clock: model updates at the edge, outputs are compared 1 time unit later
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; sel = '0; inv = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) in_a[k] = '0;
        for (int k = 0; k < 5; k++) in_w[k] = '0;
        model_reset();

        // Reset held for two cycles: everything must read zero
        repeat (2) @(negedge clk);
        check("rst_out",  out_a, 0);
        check("rst_val",  val_a, 0);
        check("rst_err",  err_a, 0);
        check("rst_cnt",  cnt_a, 0);
        check("rst_wout", out_w, 0);
        check("rst_wcnt", cnt_w, 0);

        // Reset then select 0,1,2
        in_a[0] = 5'd5; in_a[1] = 5'd7; in_a[2] = 5'd9;
        for (int k = 0; k < 5; k++) in_w[k] = $urandom;
        inv = 1'b1; sel = 3'd0;
        rst_n = 1'b1;
        step("sel0"); check("sel0_out", out_a, 5); check("sel0_val", val_a, 1);
        sel = 3'd1;
        step("sel1"); check("sel1_out", out_a, 7);
        sel = 3'd2;
        step("sel2"); check("sel2_out", out_a, 9); check("sel2_err", err_a, 0);

        // Out-of-range select, valid then invalid
        sel = 3'd3;
        step("oor_v"); check("oor_out", out_a, 0); check("oor_err", err_a, 1);
        check("oor_cnt", cnt_a, 1);
        inv = 1'b0;
        step("oor_i"); check("oor_i_err", err_a, 0); check("oor_i_cnt", cnt_a, 1);

        // Stall holds the captured value; dropped inputs are not queued
        inv = 1'b1; sel = 3'd1;
        step("pre_stall");
        stall = 1'b1; sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall_out", out_a, 7);
            check("stall_val", val_a, 1);
        end
        stall = 1'b0;
        step("unstall"); check("unstall_out", out_a, 9);

        // Flush beats stall and leaves the counter alone
        sel = 3'd3;
        step("pre_flush"); check("pre_flush_cnt", cnt_a, 2);
        stall = 1'b1; flush = 1'b1;
        step("flush");
        check("flush_out", out_a, 0); check("flush_val", val_a, 0);
        check("flush_err", err_a, 0); check("flush_cnt", cnt_a, 2);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges while OutValid=1
        sel = 3'd1;
        step("pre_arst"); check("pre_arst_val", val_a, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        check("arst_val", val_a, 0); check("arst_cnt", cnt_a, 0);
        check("arst_wval", val_w, 0);
        step("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the narrow counter
        sel = 3'd3; inv = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step("sat");
            check("sat_s", cnt_s, (i < 7) ? i : 7);
            check("sat_a", cnt_a, i);
        end

        // Wide build: Sel=4 is the last legal code, Sel=5 the first illegal one
        sel = 3'd4;
        step("w4"); check("w4_out", out_w, in_w[4]); check("w4_err", err_w, 0);
        sel = 3'd5;
        step("w5"); check("w5_out", out_w, 0); check("w5_err", err_w, 1);
        check("w5_cnt", cnt_w, 1);

        // Randomised traffic, including rare asynchronous resets
        for (int n = 0; n < 400; n++) begin
            sel   = 3'($urandom_range(0, 7));
            inv   = ($urandom % 4) != 0;
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 10) == 0;
            if (($urandom % 3) == 0) begin
                for (int k = 0; k < 3; k++) in_a[k] = 5'($urandom);
                for (int k = 0; k < 5; k++) in_w[k] = $urandom;
            end
            rst_n = ($urandom % 50) != 0;
            if (!rst_n) model_reset();
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
